// File: rtl/text_line_overlay_ctrl.sv
// Text line overlay controller: owns a one-line character buffer, drives the
// 5x8 glyph generator from the VGA pixel counters and returns a lit-pixel flag
// with a fixed two-clock latency relative to the hc/vc it was computed from.
module text_line_overlay_ctrl #(
    parameter int N_CHARS  = 16,
    parameter int X0       = 64,
    parameter int Y0       = 32,
    parameter int SCALE_SH = 1,
    parameter int AW       = $clog2(N_CHARS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [10:0]   hc,
    input  logic [10:0]   vc,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          push_valid,
    input  logic [7:0]    push_char,
    input  logic          clr_req,
    output logic          busy,
    output logic [AW-1:0] cursor,
    output logic [7:0]    char_select,
    output logic [2:0]    char_x,
    output logic [2:0]    char_y,
    input  logic          char_pixel,
    output logic          pix_on
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [7:0] SPACE = 8'd32;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [AW-1:0] cursor_q, cursor_d;
    logic [7:0]    text_q [N_CHARS];
    logic [7:0]    text_d [N_CHARS];

    logic [10:0]   dx, dy, sx, sy;
    logic          in_box;
    logic [AW-1:0] col;
    logic [2:0]    gx, gy;

    logic          in_box1_q, in_box1_d;
    logic [AW-1:0] col1_q, col1_d;
    logic [2:0]    gx1_q, gx1_d, gy1_q, gy1_d;
    logic [7:0]    char_select_q, char_select_d;
    logic [2:0]    char_x_q, char_x_d, char_y_q, char_y_d;
    logic          in_box2_q, in_box2_d;
    logic          gap2_q, gap2_d;
    logic          blank2_q, blank2_d;
    logic          pix_on_q, pix_on_d;

    // Map pixel counters to a character cell; the origin checks stop a
    // negative offset from aliasing into the box through 11-bit wrap.
    always_comb begin
        dx     = hc - 11'(X0);
        dy     = vc - 11'(Y0);
        sx     = dx >> SCALE_SH;
        sy     = dy >> SCALE_SH;
        in_box = (hc >= 11'(X0)) && (vc >= 11'(Y0)) &&
                 (sx < 11'(N_CHARS * 8)) && (sy < 11'd8);
        col    = sx[AW+2:3];
        gx     = sx[2:0];
        gy     = sy[2:0];
    end

    // Display pipeline: stage 1 holds geometry, stage 2 drives the glyph
    // generator, stage 3 gates its pixel with box, gap and blank-space masks.
    always_comb begin
        in_box1_d     = in_box;
        col1_d        = col;
        gx1_d         = gx;
        gy1_d         = gy;
        char_select_d = text_q[col1_q];
        char_x_d      = (gx1_q > 3'd4) ? 3'd0 : gx1_q;
        char_y_d      = gy1_q;
        in_box2_d     = in_box1_q;
        gap2_d        = (gx1_q > 3'd4);
        blank2_d      = (text_q[col1_q] == SPACE);
        pix_on_d      = in_box2_q & ~gap2_q & ~blank2_q & char_pixel;
    end

    // Buffer update paths and clear sequencer; clear wins over random write,
    // which wins over push, and everything is ignored while clearing.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        cursor_d  = cursor_q;
        text_d    = text_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else if (wr_en) begin
                    text_d[wr_addr] = wr_data;
                end else if (push_valid) begin
                    text_d[cursor_q] = push_char;
                    cursor_d         = cursor_q + 1'b1;
                end
            end
            CLEAR: begin
                text_d[clr_idx_q] = SPACE;
                clr_idx_d         = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(N_CHARS - 1)) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, buffer and pipeline registers with asynchronous reset to a blank line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            clr_idx_q     <= '0;
            cursor_q      <= '0;
            for (int i = 0; i < N_CHARS; i++) text_q[i] <= SPACE;
            in_box1_q     <= 1'b0;
            col1_q        <= '0;
            gx1_q         <= 3'd0;
            gy1_q         <= 3'd0;
            char_select_q <= SPACE;
            char_x_q      <= 3'd0;
            char_y_q      <= 3'd0;
            in_box2_q     <= 1'b0;
            gap2_q        <= 1'b0;
            blank2_q      <= 1'b0;
            pix_on_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_idx_q     <= clr_idx_d;
            cursor_q      <= cursor_d;
            text_q        <= text_d;
            in_box1_q     <= in_box1_d;
            col1_q        <= col1_d;
            gx1_q         <= gx1_d;
            gy1_q         <= gy1_d;
            char_select_q <= char_select_d;
            char_x_q      <= char_x_d;
            char_y_q      <= char_y_d;
            in_box2_q     <= in_box2_d;
            gap2_q        <= gap2_d;
            blank2_q      <= blank2_d;
            pix_on_q      <= pix_on_d;
        end
    end

    assign busy        = (state_q == CLEAR);
    assign cursor      = cursor_q;
    assign char_select = char_select_q;
    assign char_x      = char_x_q;
    assign char_y      = char_y_q;
    assign pix_on      = pix_on_q;

endmodule

// File: tb/tb_text_line_overlay_ctrl.sv
// Bench for text_line_overlay_ctrl: a stand-in glyph generator plus a
// behavioural model of the text line, checked every clock against the DUT.
module tb_text_line_overlay_ctrl;

    localparam int N_CHARS  = 16;
    localparam int X0       = 64;
    localparam int Y0       = 32;
    localparam int SCALE_SH = 0;
    localparam int AW       = $clog2(N_CHARS);
    localparam int CELL     = 8 << SCALE_SH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [10:0]   hc = '0, vc = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          push_valid = 1'b0;
    logic [7:0]    push_char = '0;
    logic          clr_req = 1'b0;
    logic          busy;
    logic [AW-1:0] cursor;
    logic [7:0]    char_select;
    logic [2:0]    char_x, char_y;
    logic          char_pixel;
    logic          pix_on;

    int check_count = 0;
    int error_count = 0;

    // Reference model state: the line of text, clear progress, cursor, and the
    // expected values of each visible output.
    int m_text [N_CHARS];
    int m_cursor, m_clr_left;
    int s1_inbox, s1_col, s1_gx, s1_gy;
    int e_sel, e_x, e_y, e_inbox, e_gap, e_pix;

    text_line_overlay_ctrl #(
        .N_CHARS(N_CHARS), .X0(X0), .Y0(Y0), .SCALE_SH(SCALE_SH), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .push_valid(push_valid), .push_char(push_char), .clr_req(clr_req),
        .busy(busy), .cursor(cursor), .char_select(char_select),
        .char_x(char_x), .char_y(char_y), .char_pixel(char_pixel), .pix_on(pix_on)
    );

    always #5 clk = ~clk;

    // Stand-in font: space is fully lit so only the blank mask keeps it dark;
    // row 1 of '1' is 00110; every other row is a hash of code and row.
    function automatic logic glyph(input logic [7:0] s, input logic [2:0] x, input logic [2:0] y);
        logic [4:0]  row;
        logic [15:0] h;
        if (s == 8'd32) row = 5'b11111;
        else if (s == 8'd49 && y == 3'd1) row = 5'b00110;
        else begin
            h   = 16'(s) * 16'd37 + 16'(y) * 16'd11 + 16'd5;
            row = h[6:2];
        end
        if (x > 3'd4) return 1'b0;
        return row[3'd4 - x];
    endfunction

    assign char_pixel = glyph(char_select, char_x, char_y);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N_CHARS; i++) m_text[i] = 32;
        m_cursor = 0; m_clr_left = 0;
        s1_inbox = 0; s1_col = 0; s1_gx = 0; s1_gy = 0;
        e_sel = 32; e_x = 0; e_y = 0; e_inbox = 0; e_gap = 0; e_pix = 0;
    endtask

    // One rising edge of the model: outputs computed from the text as it
    // stood before this edge, then the text/cursor/clear updates.
    task automatic modelEdge();
        int dx, dy, sx, sy;
        e_pix   = (e_inbox != 0 && e_gap == 0 && e_sel != 32 &&
                   glyph(8'(e_sel), 3'(e_x), 3'(e_y))) ? 1 : 0;
        e_sel   = m_text[s1_col];
        e_x     = (s1_gx > 4) ? 0 : s1_gx;
        e_y     = s1_gy;
        e_inbox = s1_inbox;
        e_gap   = (s1_gx > 4) ? 1 : 0;
        dx = (int'(hc) - X0) & 32'h7FF;
        dy = (int'(vc) - Y0) & 32'h7FF;
        sx = dx >> SCALE_SH;
        sy = dy >> SCALE_SH;
        s1_inbox = (int'(hc) >= X0 && int'(vc) >= Y0 && sx < N_CHARS * 8 && sy < 8) ? 1 : 0;
        s1_col   = (sx / 8) % N_CHARS;
        s1_gx    = sx % 8;
        s1_gy    = sy % 8;
        if (m_clr_left > 0) begin
            m_text[N_CHARS - m_clr_left] = 32;
            m_clr_left--;
            if (m_clr_left == 0) m_cursor = 0;
        end else if (clr_req) begin
            m_clr_left = N_CHARS;
        end else if (wr_en) begin
            m_text[wr_addr] = wr_data;
        end else if (push_valid) begin
            m_text[m_cursor] = push_char;
            m_cursor = (m_cursor + 1) % N_CHARS;
        end
    endtask

    task automatic applyStimulus(input int h, input int v, input logic we, input int wa, input int wd,
                                 input logic pv, input int pc, input logic cr);
        hc = 11'(h); vc = 11'(v);
        wr_en = we; wr_addr = AW'(wa); wr_data = 8'(wd);
        push_valid = pv; push_char = 8'(pc); clr_req = cr;
    endtask

    // Advance one clock, update the model on the edge and compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) modelReset(); else modelEdge();
        @(negedge clk);
        checkOutput("pix_on", pix_on, e_pix);
        checkOutput("char_select", char_select, e_sel);
        checkOutput("char_x", char_x, e_x);
        checkOutput("char_y", char_y, e_y);
        checkOutput("busy", busy, (m_clr_left > 0) ? 1 : 0);
        checkOutput("cursor", cursor, m_cursor);
    endtask

    task automatic scanColumns(input int row);
        for (int c = 0; c < N_CHARS; c++) begin
            applyStimulus(X0 + c * CELL, Y0 + (row << SCALE_SH), 0, 0, 0, 0, 0, 0);
            tick();
        end
        tick(); tick();
    endtask

    initial begin
        int busy_cycles;
        modelReset();
        #12 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_cursor", cursor, 0);
        checkOutput("reset_select", char_select, 32);

        // Empty buffer: raster over and around the box must stay dark.
        for (int v = Y0 - 2; v < Y0 + 8 * (1 << SCALE_SH) + 2; v++)
            for (int h = X0 - 4; h < X0 + N_CHARS * CELL + 4; h += 3) begin
                applyStimulus(h, v, 0, 0, 0, 0, 0, 0);
                tick();
            end

        // '1' in cell 0, probe glyph column 2 row 1, then the gap column.
        applyStimulus(0, 0, 1, 0, 49, 0, 0, 0);
        tick();
        applyStimulus(X0 + 2, Y0 + 1, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        checkOutput("one_select", char_select, 49);
        checkOutput("one_x", char_x, 2);
        checkOutput("one_y", char_y, 1);
        tick();
        checkOutput("one_pix", pix_on, 1);
        applyStimulus(X0 + 5, Y0 + 1, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        checkOutput("gap_pix", pix_on, 0);

        // Seventeen pushes: cursor steps and wraps, the last overwrites cell 0.
        for (int i = 0; i < N_CHARS + 1; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 97 + i, 0);
            tick();
            checkOutput("push_cursor", cursor, (i + 1) % N_CHARS);
        end
        scanColumns(2);

        // Write and push together: write wins, push is dropped.
        applyStimulus(0, 0, 1, 3, 99, 1, 100, 0);
        tick();
        checkOutput("collide_cursor", cursor, 1);
        applyStimulus(X0 + 3 * CELL, Y0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        checkOutput("collide_select", char_select, 99);

        // Clear a full buffer while hammering it with requests.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cycles++;
            applyStimulus(X0 + i * CELL, Y0 + 2, 1, i, 65, 1, 66, 1);
            tick();
        end
        checkOutput("clear_cycles", busy_cycles, N_CHARS);
        checkOutput("clear_cursor", cursor, 0);
        scanColumns(3);

        // Reset in the middle of a clear.
        for (int i = 0; i < N_CHARS; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 70 + i, 0);
            tick();
        end
        applyStimulus(X0 + 9 * CELL, Y0, 0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midclr_busy", busy, 0);
        checkOutput("midclr_pix", pix_on, 0);
        tick(); tick();
        rst_n = 1'b1;
        scanColumns(4);

        // Randomised traffic over and around the box.
        for (int i = 0; i < 3000; i++) begin
            int h, v, r;
            r = $urandom_range(99);
            h = (r < 5) ? $urandom_range(2047) : $urandom_range(X0 + N_CHARS * CELL + 16, X0 - 16);
            v = (r < 5) ? $urandom_range(2047) : $urandom_range(Y0 + 8 * (1 << SCALE_SH) + 4, Y0 - 4);
            applyStimulus(h, v, $urandom_range(99) < 20, $urandom_range(N_CHARS - 1),
                          ($urandom_range(3) == 0) ? 32 : $urandom_range(33, 126),
                          $urandom_range(99) < 20, $urandom_range(32, 126),
                          $urandom_range(199) < 3);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/text_line_overlay_ctrl.md
Name: text_line_overlay_ctrl

Overview:
- Controller that sequences the 5x8 glyph generator (`characters`: select[7:0], coor_x[2:0], coor_y[2:0] -> pixel) to draw one line of text at a fixed position on the VGA frame.
- Owns an N_CHARS-entry text buffer with three update paths: random write, cursor push, and a multi-cycle clear FSM.
- Maps incoming pixel counters to character code plus glyph coordinates, and returns a pipelined pix_on aligned to a fixed 2-cycle latency.
- Sits between the VGA timing generator and the colour mux.

Parameters:
- N_CHARS, 16, text buffer depth and line length in characters (power of two, 2..64).
- X0, 64, left edge of the text box in pixels.
- Y0, 32, top edge of the text box in pixels.
- SCALE_SH, 1, glyph magnification as a shift: each glyph pixel is (1<<SCALE_SH) screen pixels square.
- AW, $clog2(N_CHARS), buffer address width.

Ports:
- clk  in  1  system clock (all logic on rising edge).
- rst_n  in  1  asynchronous active-low reset.
- hc  in  11  current horizontal pixel counter.
- vc  in  11  current vertical pixel counter.
- wr_en  in  1  random write strobe.
- wr_addr  in  AW  random write address.
- wr_data  in  8  random write ASCII code.
- push_valid  in  1  append push_char at the cursor.
- push_char  in  8  ASCII code to append.
- clr_req  in  1  start clearing the buffer to spaces.
- busy  out  1  high while the clear FSM runs.
- cursor  out  AW  next push position.
- char_select  out  8  to characters.select.
- char_x  out  3  to characters.coor_x.
- char_y  out  3  to characters.coor_y.
- char_pixel  in  1  from characters.pixel (combinational return).
- pix_on  out  1  text pixel lit, aligned to hc/vc sampled 2 cycles earlier.

Behaviour:
- Reset (async, rst_n=0): all buffer entries = 8'd32 (space); cursor=0; busy=0; FSM=IDLE; char_select=8'd32; char_x=0; char_y=0; pix_on=0; pipeline valid bits=0.
- Geometry: dx=hc-X0, dy=vc-Y0 (11-bit, compared unsigned after checking hc>=X0, vc>=Y0).
  - in_box = hc>=X0 && vc>=Y0 && (dx>>SCALE_SH) < N_CHARS*8 && (dy>>SCALE_SH) < 8.
  - col = (dx>>SCALE_SH)>>3; gx = (dx>>SCALE_SH)[2:0]; gy = (dy>>SCALE_SH)[2:0].
  - Cell is 8 wide: gx 0..4 are glyph columns, gx 5..7 are inter-character gap and never lit.
  - gx maps directly to coor_x (0 = leftmost); gy maps directly to coor_y (0 = top row).
- Pipeline:
  - Edge t: register in_box1, col1, gx1, gy1 from hc/vc.
  - Edge t+1: char_select<=buf[col1]; char_x<=gx1 (0 if gx1>4); char_y<=gy1; in_box2<=in_box1; gap2<=(gx1>4); blank2<=(buf[col1]==8'd32).
  - Edge t+2: pix_on<=in_box2 & ~gap2 & ~blank2 & char_pixel.
  - Latency is exactly 2 clocks; pix_on=0 everywhere outside the box.
  - Space is forced dark because the generator renders unknown codes as '.'.
- Buffer read during write: a read returns the pre-write value; the new value is visible from the next edge.
- FSM states and transitions:
  - IDLE: clr_req=1 -> CLEAR with clr_idx=0, busy=1.
  - IDLE, else wr_en=1 -> buf[wr_addr]<=wr_data.
  - IDLE, else push_valid=1 -> buf[cursor]<=push_char, cursor<=cursor+1 (wraps N_CHARS-1 -> 0).
  - Priority in IDLE: clr_req > wr_en > push_valid. A losing request is dropped (no queueing, cursor unchanged).
  - CLEAR: buf[clr_idx]<=8'd32 each cycle; clr_idx increments. After writing index N_CHARS-1 -> IDLE, busy=0, cursor=0.
  - Clear takes exactly N_CHARS cycles with busy high.
  - In CLEAR, wr_en, push_valid and clr_req are all ignored.
- Display pipeline keeps running during CLEAR and shows the partially cleared buffer.
- Async reset mid-CLEAR: immediate return to the reset state; the buffer is fully spaced.
- Widths: hc/vc arithmetic is 11 bits with no wrap; hc<X0 or vc<Y0 gives in_box=0 (no negative aliasing).

Test Plan:
- Reset then scan the frame -> char_select=32 and pix_on=0 for all hc/vc; busy=0, cursor=0.
- With SCALE_SH=0, write wr_addr=0 '1' (8'd49), drive hc=X0+2, vc=Y0+1 -> 1 cycle later char_select=49, char_x=2, char_y=1; 2 cycles later pix_on=1 (row 00110, bit 2). hc=X0+5 -> pix_on=0 (gap).
- Push 'a','b' then 15 more chars with N_CHARS=16 -> cursor goes 0,1,2,...,15,0; the 17th push overwrites buf[0].
- Same cycle wr_en (addr 3, 'c') and push_valid ('d') -> buf[3]='c', cursor unchanged, 'd' dropped.
- clr_req with a full buffer -> busy high for exactly 16 cycles; wr_en/push during those cycles have no effect; afterwards all entries are 32 and cursor=0.
- Assert rst_n low at CLEAR cycle 5 -> busy=0 and pix_on=0 immediately; buffer is all spaces after release.
